hyperbus_wb_bridge: RTL
=======================

HYPERBUS_WB_BRIDGE -- requirements
Module: hyperbus_wb_bridge

Interface
REQ-001 SHALL have parameter WB_DATA_WIDTH, default 32: Wishbone data width; an integer multiple of HBUS_DATA_WIDTH.
REQ-002 SHALL have parameter WB_ADDR_WIDTH, default 32: Wishbone byte-address width.
REQ-003 SHALL have parameter HBUS_ADDR_WIDTH, default 32: HyperBus word-address width.
REQ-004 SHALL have parameter HBUS_DATA_WIDTH, default 16: HyperBus word width (multiple of 8).
REQ-005 SHALL have parameter TIMEOUT, default 1023: maximum wait cycles per HyperBus beat; 0 disables the timeout.
REQ-006 SHALL use one clock; reset is asynchronous and active-low.
REQ-007 Ports (name, direction, width, meaning):
- wb_clk, in, 1: single clock.
- wb_rst_n, in, 1: async active-low reset.
- wb_adr_i, in, WB_ADDR_WIDTH: byte address.
- wb_dat_i, in, WB_DATA_WIDTH: write data.
- wb_sel_i, in, WB_DATA_WIDTH/8: byte selects.
- wb_we_i, wb_cyc_i, wb_stb_i, in, 1 each: Wishbone classic control.
- wb_dat_o, out, WB_DATA_WIDTH: read data.
- wb_ack_o, wb_err_o, out, 1 each: termination.
- wb_rty_o, out, 1: tied 0.
- hbus_adr_o, out, HBUS_ADDR_WIDTH: word address of the current beat.
- hbus_dat_o, out, HBUS_DATA_WIDTH: write beat data.
- hbus_mask_o, out, HBUS_DATA_WIDTH/8: write byte mask (1 = write byte).
- hbus_rrq, hbus_wrq, out, 1 each: beat requests.
- hbus_dat_i, in, HBUS_DATA_WIDTH: read beat data.
- hbus_ready, in, 1: request accepted.
- hbus_valid, in, 1: read beat data valid.

Function
REQ-008 SHALL define BEATS = WB_DATA_WIDTH/HBUS_DATA_WIDTH; each Wishbone transfer becomes BEATS HyperBus beats, lowest-order beat first.
REQ-009 SHALL issue beat k at hbus_adr_o = (wb_adr_i >> log2(HBUS_DATA_WIDTH/8)) + k, truncated or zero-extended to HBUS_ADDR_WIDTH.
REQ-010 SHALL use FSM states IDLE, REQ, RDATA, DONE: IDLE->REQ on cyc&stb with ack and err both low; latch adr/dat/sel/we; beat counter = 0.
REQ-011 In REQ, SHALL hold hbus_wrq (if we) or hbus_rrq (if not we) high, with hbus_adr_o/dat_o/mask_o stable, until hbus_ready is sampled high.
REQ-012 Write: on hbus_ready, SHALL increment beat; if beat = BEATS-1, ->DONE, else stay in REQ.
REQ-013 Write beats whose mask (the sel slice) is all zero SHALL be skipped without asserting hbus_wrq; a transfer with sel = 0 SHALL go IDLE->DONE in one cycle.
REQ-014 Read: on hbus_ready, ->RDATA; on hbus_valid, SHALL capture hbus_dat_i into slice k of the read register; if last beat ->DONE, else ->REQ. Reads always fetch all beats, regardless of sel.
REQ-015 DONE SHALL drive wb_ack_o high for exactly one cycle, then ->IDLE; wb_dat_o SHALL hold the assembled word from the ack cycle until the next read completes.
REQ-016 hbus_rrq and hbus_wrq SHALL never be high together and SHALL be low outside REQ.
REQ-017 A wait counter SHALL clear on every state change and count cycles in REQ/RDATA; at TIMEOUT (if nonzero), SHALL drop requests, pulse wb_err_o one cycle instead of ack, and ->IDLE.
REQ-018 If wb_cyc_i deasserts mid-transfer, the in-flight beat SHALL complete (ready, plus valid for reads), then ->IDLE with no ack/err.
REQ-019 The cycle after ack/err is always IDLE; a new request SHALL be accepted no earlier than the cycle after that.

Reset
REQ-020 While wb_rst_n is low (async): state IDLE, beat and wait counters 0, wb_ack_o, wb_err_o, hbus_rrq, hbus_wrq = 0, wb_dat_o = 0, hbus_adr_o/dat_o/mask_o = 0; reset mid-transfer aborts immediately.

Verification
REQ-021 Write 0xDEADBEEF @0x100, sel=1111 -> beats adr 0x80 dat 0xBEEF mask 11, then adr 0x81 dat 0xDEAD mask 11; one ack after the second ready.
REQ-022 Write sel=1100 @0x100 -> single beat adr 0x81 mask 11; sel=0010 -> single beat adr 0x80 mask 10; sel=0000 -> ack with no hbus_wrq.
REQ-023 Read @0x200, valid data 0x5678 then 0x1234 (ready delayed 3 cycles) -> wb_dat_o = 0x12345678 at the single ack.
REQ-024 TIMEOUT=8, hbus_ready held low -> hbus_rrq drops and wb_err_o pulses after 8 wait cycles; no ack.
REQ-025 wb_rst_n asserted low during RDATA -> outputs zero combinationally; after release, the next read completes normally.
REQ-026 wb_cyc_i dropped after first write beat is accepted -> no second beat, no ack; the following transfer is correct.

Source files
------------

// File: rtl/hyperbus_wb_bridge_if.sv
// Wishbone classic slave-side bundle for the HyperBus bridge.
// Signal names keep the bridge's _i/_o orientation.
interface hyperbus_wb_bridge_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   wb_adr_i;
  logic [DW-1:0]   wb_dat_i;
  logic [DW/8-1:0] wb_sel_i;
  logic            wb_we_i;
  logic            wb_cyc_i;
  logic            wb_stb_i;
  logic [DW-1:0]   wb_dat_o;
  logic            wb_ack_o;
  logic            wb_err_o;
  logic            wb_rty_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/hyperbus_wb_bridge.sv
// Wishbone classic to HyperBus beat bridge.
// Splits each bus word into narrow beats, low beat first.
module hyperbus_wb_bridge #(
  parameter int WB_DATA_WIDTH   = 32,
  parameter int WB_ADDR_WIDTH   = 32,
  parameter int HBUS_ADDR_WIDTH = 32,
  parameter int HBUS_DATA_WIDTH = 16,
  parameter int TIMEOUT         = 1023
) (
  input  logic                         wb_clk,
  input  logic                         wb_rst_n,
  hyperbus_wb_bridge_if.slave          wb,
  output logic [HBUS_ADDR_WIDTH-1:0]   hbus_adr_o,
  output logic [HBUS_DATA_WIDTH-1:0]   hbus_dat_o,
  output logic [HBUS_DATA_WIDTH/8-1:0] hbus_mask_o,
  output logic                         hbus_rrq,
  output logic                         hbus_wrq,
  input  logic [HBUS_DATA_WIDTH-1:0]   hbus_dat_i,
  input  logic                         hbus_ready,
  input  logic                         hbus_valid
);
  localparam int BEATS  = WB_DATA_WIDTH / HBUS_DATA_WIDTH;
  localparam int HB     = HBUS_DATA_WIDTH / 8;
  localparam int SW     = WB_DATA_WIDTH / 8;
  localparam int HDW    = HBUS_DATA_WIDTH;
  localparam int SHIFT  = $clog2(HB);
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WW     = $clog2(TIMEOUT + 2);
  localparam int TO_LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam int XW     = ((WB_ADDR_WIDTH > HBUS_ADDR_WIDTH) ?
                           WB_ADDR_WIDTH : HBUS_ADDR_WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, REQ, RDATA, DONE} state_t;

  function automatic logic [HBUS_ADDR_WIDTH-1:0] beat_adr(
    input logic [WB_ADDR_WIDTH-1:0] a, input int k);
    logic [XW-1:0] w;
    w = XW'(a >> SHIFT) + XW'(k);
    return w[HBUS_ADDR_WIDTH-1:0];
  endfunction

  // First beat at or after 'from' with a non-empty byte mask.
  function automatic int next_wr(input logic [SW-1:0] sel, input int from);
    int r;
    r = BEATS;
    for (int k = BEATS - 1; k >= from; k--)
      if (sel[k*HB +: HB] != '0) r = k;
    return r;
  endfunction

  state_t                     state_q;
  logic [BW-1:0]              beat_q;
  logic [WW-1:0]              wait_q;
  logic                       abort_q;
  logic [WB_ADDR_WIDTH-1:0]   adr_q;
  logic [WB_DATA_WIDTH-1:0]   dat_q;
  logic [SW-1:0]              sel_q;
  logic                       we_q;
  logic [WB_DATA_WIDTH-1:0]   rbuf_q;
  logic [WB_DATA_WIDTH-1:0]   rdat_q;
  logic                       ack_q;
  logic                       err_q;
  logic                       rrq_q;
  logic                       wrq_q;
  logic [HBUS_ADDR_WIDTH-1:0] hadr_q;
  logic [HDW-1:0]             hdat_q;
  logic [HB-1:0]              hmask_q;

  logic [WB_ADDR_WIDTH-1:0]   src_adr;
  logic [WB_DATA_WIDTH-1:0]   src_dat;
  logic [SW-1:0]              src_sel;
  logic                       src_we;
  int                         nxt0;
  int                         nxt1;
  int                         ld_k;
  int                         ld_s;
  logic [HBUS_ADDR_WIDTH-1:0] ld_adr;
  logic [HDW-1:0]             ld_dat;
  logic [HB-1:0]              ld_mask;
  logic [WB_DATA_WIDTH-1:0]   rbuf_d;
  logic                       abort_n;
  logic                       to_hit;
  logic                       last_b;

  // Pick the next beat to present and its address/data/mask.
  always_comb begin
    src_adr = (state_q == IDLE) ? wb.wb_adr_i : adr_q;
    src_dat = (state_q == IDLE) ? wb.wb_dat_i : dat_q;
    src_sel = (state_q == IDLE) ? wb.wb_sel_i : sel_q;
    src_we  = (state_q == IDLE) ? wb.wb_we_i  : we_q;
    nxt0 = next_wr(wb.wb_sel_i, 0);
    nxt1 = next_wr(sel_q, int'(beat_q) + 1);
    if (state_q == IDLE) ld_k = src_we ? nxt0 : 0;
    else if (we_q)       ld_k = nxt1;
    else                 ld_k = int'(beat_q) + 1;
    ld_s    = (ld_k < BEATS) ? ld_k : 0;
    ld_adr  = beat_adr(src_adr, ld_s);
    ld_dat  = src_we ? src_dat[ld_s*HDW +: HDW] : '0;
    ld_mask = src_we ? src_sel[ld_s*HB +: HB] : '0;
    rbuf_d  = rbuf_q;
    rbuf_d[int'(beat_q)*HDW +: HDW] = hbus_dat_i;
    abort_n = abort_q | ~wb.wb_cyc_i;
    to_hit  = (TIMEOUT != 0) && (wait_q == WW'(TO_LIM));
    last_b  = (int'(beat_q) == BEATS - 1);
  end

  // Transfer FSM with registered bus and beat outputs.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      wait_q  <= '0;
      abort_q <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      rbuf_q  <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rrq_q   <= 1'b0;
      wrq_q   <= 1'b0;
      hadr_q  <= '0;
      hdat_q  <= '0;
      hmask_q <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (wb.wb_cyc_i && wb.wb_stb_i && !ack_q && !err_q) begin
            adr_q   <= wb.wb_adr_i;
            dat_q   <= wb.wb_dat_i;
            sel_q   <= wb.wb_sel_i;
            we_q    <= wb.wb_we_i;
            abort_q <= 1'b0;
            wait_q  <= '0;
            beat_q  <= BW'(ld_s);
            if (wb.wb_we_i && nxt0 >= BEATS) begin
              state_q <= DONE;
              ack_q   <= 1'b1;
            end else begin
              state_q <= REQ;
              rrq_q   <= ~wb.wb_we_i;
              wrq_q   <= wb.wb_we_i;
              hadr_q  <= ld_adr;
              hdat_q  <= ld_dat;
              hmask_q <= ld_mask;
            end
          end
        end
        REQ: begin
          if (hbus_ready) begin
            wait_q <= '0;
            if (!we_q) begin
              state_q <= RDATA;
              rrq_q   <= 1'b0;
              abort_q <= abort_n;
            end else if (abort_n || nxt1 >= BEATS) begin
              wrq_q   <= 1'b0;
              state_q <= abort_n ? IDLE : DONE;
              ack_q   <= ~abort_n;
            end else begin
              beat_q  <= BW'(ld_s);
              hadr_q  <= ld_adr;
              hdat_q  <= ld_dat;
              hmask_q <= ld_mask;
            end
          end else if (to_hit) begin
            state_q <= IDLE;
            wait_q  <= '0;
            rrq_q   <= 1'b0;
            wrq_q   <= 1'b0;
            err_q   <= ~abort_n;
          end else begin
            wait_q  <= wait_q + 1'b1;
            abort_q <= abort_n;
          end
        end
        RDATA: begin
          if (hbus_valid) begin
            wait_q <= '0;
            rbuf_q <= rbuf_d;
            if (abort_n) begin
              state_q <= IDLE;
            end else if (last_b) begin
              state_q <= DONE;
              ack_q   <= 1'b1;
              rdat_q  <= rbuf_d;
            end else begin
              state_q <= REQ;
              beat_q  <= BW'(ld_s);
              hadr_q  <= ld_adr;
              hdat_q  <= ld_dat;
              hmask_q <= ld_mask;
              rrq_q   <= 1'b1;
            end
          end else if (to_hit) begin
            state_q <= IDLE;
            wait_q  <= '0;
            err_q   <= ~abort_n;
          end else begin
            wait_q  <= wait_q + 1'b1;
            abort_q <= abort_n;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hbus_adr_o  = hadr_q;
  assign hbus_dat_o  = hdat_q;
  assign hbus_mask_o = hmask_q;
  assign hbus_rrq    = rrq_q;
  assign hbus_wrq    = wrq_q;
  assign wb.wb_dat_o = rdat_q;
  assign wb.wb_ack_o = ack_q;
  assign wb.wb_err_o = err_q;
  assign wb.wb_rty_o = 1'b0;
endmodule
